bbox_scanner: RTL and testbench
===============================

BBOX_SCANNER -- requirements
Module: bbox_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 100, image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 100, image height in pixels.
REQ-003 SHALL have parameter CHANNELS, default 3, memory words per pixel (1..4).
REQ-004 SHALL have parameter DATA_W, default 16, width of rddata and threshold.
REQ-005 SHALL have parameter COORD_W, default 11, width of coordinate outputs.
REQ-006 SHALL have parameter ADDR_W, default 24, width of addr.
REQ-007 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (1..4).
REQ-008 SHALL have ports, in this order:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a scan.
- abort  in  1  cancel an in-progress scan.
- threshold  in  DATA_W  foreground threshold.
- mode  in  1  0 = ANY channel >= threshold; 1 = ALL channels >= threshold.
- rd_en  out  1  read request.
- addr  out  ADDR_W  read address.
- rddata  in  DATA_W  read data, valid RD_LAT cycles after rd_en.
- busy  out  1  high in SCAN or DRAIN.
- done  out  1  results valid.
- found  out  1  at least one foreground pixel.
- x_min, x_max, y_min, y_max  out  COORD_W each  bounding box.
- pix_count  out  $clog2(WIDTH*HEIGHT+1)  number of foreground pixels.

Function
REQ-009 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-010 SHALL transition IDLE->SCAN, and DONE->SCAN, on start=1, in the same cycle latching threshold and mode and clearing internal accumulators.
REQ-011 SHALL ignore start while in SCAN or DRAIN.
REQ-012 SHALL, in SCAN, drive rd_en=1 every cycle with addr = (x*HEIGHT + y)*CHANNELS + c, where c is incremented fastest, then y, then x (column-major), starting from 0.
REQ-013 SHALL issue exactly N = WIDTH*HEIGHT*CHANNELS reads and enter DRAIN after the read with addr = N-1.
REQ-014 SHALL drive rd_en=0 outside SCAN and hold addr at its last value.
REQ-015 SHALL track (x, y, c) of returning data through an RD_LAT-deep tag pipeline, so that each rddata is matched to the read that produced it.
REQ-016 SHALL classify a pixel only after its last channel (c=CHANNELS-1) returns:
- mode=0: foreground if any channel >= threshold.
- mode=1: foreground if all channels >= threshold.
- Comparisons are unsigned.
REQ-017 SHALL, for each foreground pixel, update running min/max of x and y and increment the running count.
REQ-018 SHALL leave DRAIN after the final tagged return is accumulated, then enter DONE.
REQ-019 SHALL, on entering DONE, copy the running results to found, x_min, x_max, y_min, y_max and pix_count.
REQ-020 SHALL hold all result outputs stable from one DONE entry to the next, including throughout a subsequent scan.
REQ-021 SHALL report the empty-image values when no pixel is foreground: found=0, x_min=WIDTH-1, x_max=0, y_min=HEIGHT-1, y_max=0, pix_count=0.
REQ-022 SHALL drive done=1 exactly while in DONE, and busy=1 exactly while in SCAN or DRAIN.
REQ-023 SHALL raise done on cycle N+RD_LAT+1, counting the start-sampling cycle as cycle 0.
REQ-024 SHALL, when abort=1 in SCAN or DRAIN, go to IDLE next cycle, discard in-flight returns, and leave result outputs unchanged.
REQ-025 SHALL ignore abort in IDLE and DONE.
REQ-026 SHALL give abort priority when start and abort are both asserted.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, enter IDLE from any state, including mid-scan, and drive rd_en=0, addr=0, busy=0, done=0.
REQ-028 SHALL, on that same reset, load the empty-image values of REQ-021 into the result outputs and clear the tag pipeline.

Verification
Scenarios use WIDTH=4, HEIGHT=3, CHANNELS=3, RD_LAT=2.
REQ-029 SHALL cover: all-zero image, threshold=5, start -> done=1 at cycle 39; found=0, x_min=3, x_max=0, y_min=2, y_max=0, pix_count=0.
REQ-030 SHALL cover: pixel (1,2) channel G=9, pixel (3,0) channel B=7, threshold=5, mode=0 -> found=1, x_min=1, x_max=3, y_min=0, y_max=2, pix_count=2.
REQ-031 SHALL cover: pixel (2,1) RGB=(9,9,4), mode=1, threshold=5 -> found=0; same image with mode=0 -> found=1, x_min=x_max=2, y_min=y_max=1, pix_count=1.
REQ-032 SHALL cover: addr sequence check -> 36 consecutive rd_en cycles with addr 0..35 in order; start pulsed mid-scan -> no effect on the sequence.
REQ-033 SHALL cover: abort at cycle 10 -> IDLE at cycle 11, rd_en=0, results unchanged from the previous run; rst_n=0 at cycle 20 of a new scan -> IDLE, done=0, empty-image values on the outputs.
REQ-034 SHALL cover: back-to-back runs, start asserted in DONE -> done=0 next cycle, previous results held until the new DONE, then updated.

Source files
------------

// File: rtl/bbox_scanner.sv
// bbox_scanner: streams a WIDTH x HEIGHT image (CHANNELS words per pixel,
// column-major, channel fastest) from a memory with fixed read latency and
// reports the bounding box and count of foreground pixels.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start, abort      begin a scan / cancel an in-progress scan
//   threshold, mode   foreground threshold; 0 = any channel, 1 = all channels
//   rd_en, addr       read request and address (one per cycle while scanning)
//   rddata            read data, valid RD_LAT cycles after rd_en
//   busy, done        scan in progress / results valid
//   found, x_min, x_max, y_min, y_max, pix_count   result registers
module bbox_scanner #(
    parameter int WIDTH    = 100,
    parameter int HEIGHT   = 100,
    parameter int CHANNELS = 3,
    parameter int DATA_W   = 16,
    parameter int COORD_W  = 11,
    parameter int ADDR_W   = 24,
    parameter int RD_LAT   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [DATA_W-1:0]                    threshold,
    input  logic                                 mode,
    output logic                                 rd_en,
    output logic [ADDR_W-1:0]                    addr,
    input  logic [DATA_W-1:0]                    rddata,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 found,
    output logic [COORD_W-1:0]                   x_min,
    output logic [COORD_W-1:0]                   x_max,
    output logic [COORD_W-1:0]                   y_min,
    output logic [COORD_W-1:0]                   y_max,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pix_count
);

    localparam int N     = WIDTH * HEIGHT * CHANNELS;
    localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [COORD_W-1:0] X_EMPTY = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_EMPTY = COORD_W'(HEIGHT - 1);

    logic [1:0]         state;
    logic [DATA_W-1:0]  thr_q;
    logic               mode_q;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic [1:0]         c_cnt;

    // Tag pipeline: stage RD_LAT-1 describes the word currently on rddata.
    logic               tag_v    [RD_LAT];
    logic               tag_last [RD_LAT];
    logic [COORD_W-1:0] tag_x    [RD_LAT];
    logic [COORD_W-1:0] tag_y    [RD_LAT];
    logic [1:0]         tag_c    [RD_LAT];

    logic               out_v, out_last;
    logic [COORD_W-1:0] out_x, out_y;
    logic [1:0]         out_c;

    // Per-pixel channel flags and running results.
    logic               ch_any, ch_all, any_nxt, all_nxt, ge, pix_fg;
    logic               run_found, found_nxt;
    logic [COORD_W-1:0] run_xmin, run_xmax, run_ymin, run_ymax;
    logic [COORD_W-1:0] xmin_nxt, xmax_nxt, ymin_nxt, ymax_nxt;
    logic [CNT_W-1:0]   run_cnt, cnt_nxt;
    logic               scan_last;

    assign rd_en = (state == SCAN);
    assign busy  = (state == SCAN) || (state == DRAIN);
    assign done  = (state == DONE);

    assign out_v     = tag_v[RD_LAT-1];
    assign out_last  = tag_last[RD_LAT-1];
    assign out_x     = tag_x[RD_LAT-1];
    assign out_y     = tag_y[RD_LAT-1];
    assign out_c     = tag_c[RD_LAT-1];
    assign scan_last = (addr == ADDR_W'(N - 1));

    always_comb begin
        ge      = (rddata >= thr_q);
        any_nxt = ch_any;
        all_nxt = ch_all;
        if (out_v) begin
            if (out_c == 2'd0) begin
                any_nxt = ge;
                all_nxt = ge;
            end else begin
                any_nxt = ch_any | ge;
                all_nxt = ch_all & ge;
            end
        end
        pix_fg = out_v && (out_c == 2'(CHANNELS - 1)) && (mode_q ? all_nxt : any_nxt);

        found_nxt = run_found;
        xmin_nxt  = run_xmin;
        xmax_nxt  = run_xmax;
        ymin_nxt  = run_ymin;
        ymax_nxt  = run_ymax;
        cnt_nxt   = run_cnt;
        if (pix_fg) begin
            found_nxt = 1'b1;
            if (out_x < run_xmin) xmin_nxt = out_x;
            if (out_x > run_xmax) xmax_nxt = out_x;
            if (out_y < run_ymin) ymin_nxt = out_y;
            if (out_y > run_ymax) ymax_nxt = out_y;
            cnt_nxt = run_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            thr_q     <= '0;
            mode_q    <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            c_cnt     <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_v[i]    <= 1'b0;
                tag_last[i] <= 1'b0;
                tag_x[i]    <= '0;
                tag_y[i]    <= '0;
                tag_c[i]    <= '0;
            end
            ch_any    <= 1'b0;
            ch_all    <= 1'b0;
            run_found <= 1'b0;
            run_xmin  <= X_EMPTY;
            run_xmax  <= '0;
            run_ymin  <= Y_EMPTY;
            run_ymax  <= '0;
            run_cnt   <= '0;
            found     <= 1'b0;
            x_min     <= X_EMPTY;
            x_max     <= '0;
            y_min     <= Y_EMPTY;
            y_max     <= '0;
            pix_count <= '0;
        end else begin
            tag_v[0]    <= (state == SCAN);
            tag_last[0] <= scan_last;
            tag_x[0]    <= x_cnt;
            tag_y[0]    <= y_cnt;
            tag_c[0]    <= c_cnt;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_last[i] <= tag_last[i-1];
                tag_x[i]    <= tag_x[i-1];
                tag_y[i]    <= tag_y[i-1];
                tag_c[i]    <= tag_c[i-1];
            end

            ch_any    <= any_nxt;
            ch_all    <= all_nxt;
            run_found <= found_nxt;
            run_xmin  <= xmin_nxt;
            run_xmax  <= xmax_nxt;
            run_ymin  <= ymin_nxt;
            run_ymax  <= ymax_nxt;
            run_cnt   <= cnt_nxt;

            case (state)
                IDLE, DONE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        state     <= SCAN;
                        thr_q     <= threshold;
                        mode_q    <= mode;
                        addr      <= '0;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        c_cnt     <= '0;
                        for (int unsigned i = 0; i < RD_LAT; i++) tag_v[i] <= 1'b0;
                        ch_any    <= 1'b0;
                        ch_all    <= 1'b0;
                        run_found <= 1'b0;
                        run_xmin  <= X_EMPTY;
                        run_xmax  <= '0;
                        run_ymin  <= Y_EMPTY;
                        run_ymax  <= '0;
                        run_cnt   <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                        for (int unsigned i = 0; i < RD_LAT; i++) tag_v[i] <= 1'b0;
                    end else if (scan_last) begin
                        // addr stays on N-1 after the final read
                        state <= DRAIN;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                        if (c_cnt == 2'(CHANNELS - 1)) begin
                            c_cnt <= '0;
                            if (y_cnt == Y_EMPTY) begin
                                y_cnt <= '0;
                                x_cnt <= x_cnt + COORD_W'(1);
                            end else begin
                                y_cnt <= y_cnt + COORD_W'(1);
                            end
                        end else begin
                            c_cnt <= c_cnt + 2'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        for (int unsigned i = 0; i < RD_LAT; i++) tag_v[i] <= 1'b0;
                    end else if (out_v && out_last) begin
                        // final return is folded in this cycle, so publish the next-state values
                        state     <= DONE;
                        found     <= found_nxt;
                        x_min     <= xmin_nxt;
                        x_max     <= xmax_nxt;
                        y_min     <= ymin_nxt;
                        y_max     <= ymax_nxt;
                        pix_count <= cnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scanner.sv
// tb_bbox_scanner: self-checking bench for bbox_scanner on a 4x3 RGB image
// with a two-cycle read latency memory model. Expected results are queued
// when a scan is launched and popped when done rises.
module tb_bbox_scanner;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int C    = 3;
    localparam int DW   = 16;
    localparam int CW   = 11;
    localparam int AW   = 24;
    localparam int LAT  = 2;
    localparam int N    = W * H * C;
    localparam int CNTW = $clog2(W * H + 1);

    typedef struct packed {
        logic            found;
        logic [CW-1:0]   xmin;
        logic [CW-1:0]   xmax;
        logic [CW-1:0]   ymin;
        logic [CW-1:0]   ymax;
        logic [CNTW-1:0] cnt;
    } res_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            mode = 1'b0;
    logic [DW-1:0]   threshold = '0;
    logic            rd_en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   rddata = '0;
    logic            busy, done, found;
    logic [CW-1:0]   x_min, x_max, y_min, y_max;
    logic [CNTW-1:0] pix_count;

    logic [DW-1:0]   mem [N];
    logic [DW-1:0]   rd_d1 = '0;
    res_t            exp_q [$];
    int              addr_q [$];
    int              checks = 0;
    int              errors = 0;

    bbox_scanner #(
        .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .DATA_W(DW),
        .COORD_W(CW), .ADDR_W(AW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .threshold(threshold), .mode(mode), .rd_en(rd_en), .addr(addr),
        .rddata(rddata), .busy(busy), .done(done), .found(found),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    // Memory: data for a read appears LAT cycles later; idle slots carry
    // all-ones so any stray accumulation shows up as a foreground pixel.
    always @(posedge clk) begin
        rd_d1  <= (rd_en && addr < AW'(N)) ? mem[addr[5:0]] : '1;
        rddata <= rd_d1;
    end

    function automatic res_t mk(input logic f, input int x0, input int x1,
                                input int y0, input int y1, input int n);
        res_t r;
        r.found = f;
        r.xmin  = CW'(x0);
        r.xmax  = CW'(x1);
        r.ymin  = CW'(y0);
        r.ymax  = CW'(y1);
        r.cnt   = CNTW'(n);
        return r;
    endfunction

    function automatic res_t empty_res();
        return mk(1'b0, W - 1, 0, H - 1, 0, 0);
    endfunction

    function automatic res_t dut_res();
        return res_t'({found, x_min, x_max, y_min, y_max, pix_count});
    endfunction

    // Reference: walk the image pixel by pixel.
    function automatic res_t model(input logic [DW-1:0] thr, input logic md);
        res_t r = empty_res();
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) begin
                logic any_ge = 1'b0;
                logic all_ge = 1'b1;
                for (int c = 0; c < C; c++) begin
                    if (mem[(x * H + y) * C + c] >= thr) any_ge = 1'b1;
                    else all_ge = 1'b0;
                end
                if (md ? all_ge : any_ge) begin
                    r.found = 1'b1;
                    if (CW'(x) < r.xmin) r.xmin = CW'(x);
                    if (CW'(x) > r.xmax) r.xmax = CW'(x);
                    if (CW'(y) < r.ymin) r.ymin = CW'(y);
                    if (CW'(y) > r.ymax) r.ymax = CW'(y);
                    r.cnt = r.cnt + CNTW'(1);
                end
            end
        end
        return r;
    endfunction

    task automatic clear_image();
        for (int i = 0; i < N; i++) mem[i] = '0;
    endtask

    // Called at a falling edge: start is sampled at the next rising edge
    // (cycle 0); returns at the falling edge of cycle 1. Inputs are then
    // scrambled to show the scan uses the latched threshold/mode.
    task automatic pulse_start(input logic [DW-1:0] thr, input logic md);
        threshold = thr;
        mode      = md;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        threshold = ~thr;
        mode      = ~md;
    endtask

    task automatic launch(input logic [DW-1:0] thr, input logic md, input res_t e);
        exp_q.push_back(e);
        pulse_start(thr, md);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        res_t r;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        r = dut_res();
        checks++; if (r !== empty_res()) begin errors++; $display("FAIL reset_results: got %h expected %h", r, empty_res()); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int cyc;
        res_t r, e;
        clear_image();
        launch(16'd5, 1'b0, mk(1'b0, 3, 0, 2, 0, 0));
        wait_done(cyc);
        checks++; if (cyc !== 39) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 39", cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_in_done: got %b expected 0", busy); end
        r = dut_res(); e = exp_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL empty_results: got %h expected %h", r, e); end
    endtask

    task automatic test_two_pixels();
        int cyc;
        res_t r, e;
        clear_image();
        mem[16] = 16'd9;  // (1,2) G
        mem[29] = 16'd7;  // (3,0) B
        launch(16'd5, 1'b0, mk(1'b1, 1, 3, 0, 2, 2));
        wait_done(cyc);
        checks++; if (cyc !== 39) begin errors++; $display("FAIL two_px_done_cycle: got %0d expected 39", cyc); end
        r = dut_res(); e = exp_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL two_px_results: got %h expected %h", r, e); end
    endtask

    task automatic test_mode();
        int cyc;
        res_t r, e;
        clear_image();
        mem[21] = 16'd9;  // (2,1) R
        mem[22] = 16'd9;  // (2,1) G
        mem[23] = 16'd4;  // (2,1) B
        launch(16'd5, 1'b1, mk(1'b0, 3, 0, 2, 0, 0));
        wait_done(cyc);
        r = dut_res(); e = exp_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL mode_all_results: got %h expected %h", r, e); end
        launch(16'd5, 1'b0, mk(1'b1, 2, 2, 1, 1, 1));
        wait_done(cyc);
        checks++; if (cyc !== 39) begin errors++; $display("FAIL mode_any_done_cycle: got %0d expected 39", cyc); end
        r = dut_res(); e = exp_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL mode_any_results: got %h expected %h", r, e); end
    endtask

    task automatic test_addr_seq();
        int dcyc = 0;
        int a;
        res_t r, e;
        for (int i = 0; i < N; i++) addr_q.push_back(i);
        launch(16'd5, 1'b0, mk(1'b1, 2, 2, 1, 1, 1));
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1 && dcyc == 0) dcyc = k;
            if (k <= N) begin
                a = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
                checks++; if (rd_en !== 1'b1 || addr !== AW'(a)) begin
                    errors++; $display("FAIL addr_seq_c%0d: got rd_en=%b addr=%0d expected rd_en=1 addr=%0d", k, rd_en, addr, a);
                end
            end else begin
                checks++; if (rd_en !== 1'b0 || addr !== AW'(N - 1)) begin
                    errors++; $display("FAIL addr_hold_c%0d: got rd_en=%b addr=%0d expected rd_en=0 addr=%0d", k, rd_en, addr, N - 1);
                end
            end
            if (k == 10) start = 1'b1;
            if (k == 11) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (dcyc !== 39) begin errors++; $display("FAIL addr_seq_done_cycle: got %0d expected 39", dcyc); end
        r = dut_res(); e = exp_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL addr_seq_results: got %h expected %h", r, e); end
    endtask

    task automatic test_abort();
        int cyc;
        res_t r, e;
        res_t prev = mk(1'b1, 2, 2, 1, 1, 1);
        mem[0] = 16'd50;
        pulse_start(16'd5, 1'b0);
        repeat (9) @(negedge clk);  // cycle 10
        abort = 1'b1;
        @(negedge clk);             // cycle 11
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b rd_en=%b done=%b expected 0 0 0", busy, rd_en, done);
        end
        checks++; if (addr !== AW'(9)) begin errors++; $display("FAIL abort_addr_hold: got %0d expected 9", addr); end
        repeat (4) @(negedge clk);
        r = dut_res();
        checks++; if (r !== prev || busy !== 1'b0) begin
            errors++; $display("FAIL abort_results_kept: got %h busy=%b expected %h busy=0", r, busy, prev);
        end

        pulse_start(16'd5, 1'b0);
        repeat (19) @(negedge clk); // cycle 20
        rst_n = 1'b0;
        @(negedge clk);             // cycle 21
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0 || addr !== '0) begin
            errors++; $display("FAIL midscan_reset_ctrl: got busy=%b rd_en=%b done=%b addr=%0d expected 0 0 0 0", busy, rd_en, done, addr);
        end
        r = dut_res();
        checks++; if (r !== empty_res()) begin errors++; $display("FAIL midscan_reset_results: got %h expected %h", r, empty_res()); end
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'd5, 1'b0, mk(1'b1, 0, 2, 0, 1, 2));
        wait_done(cyc);
        checks++; if (cyc !== 39) begin errors++; $display("FAIL post_reset_done_cycle: got %0d expected 39", cyc); end
        r = dut_res(); e = exp_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL post_reset_results: got %h expected %h", r, e); end

        // In DONE: simultaneous start and abort must not start a scan.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL start_abort_prio: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit hold_ok = 1'b1;
        res_t r, e;
        res_t held = mk(1'b1, 0, 2, 0, 1, 2);
        clear_image();
        mem[16] = 16'd9;
        mem[29] = 16'd7;
        launch(16'd5, 1'b0, mk(1'b1, 1, 3, 0, 2, 2));
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: got done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            if (dut_res() !== held) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        checks++; if (!hold_ok) begin errors++; $display("FAIL b2b_results_held: got changing results expected %h", held); end
        checks++; if (cyc !== 39) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 39", cyc); end
        r = dut_res(); e = exp_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL b2b_results: got %h expected %h", r, e); end
    endtask

    task automatic test_random();
        int cyc;
        res_t r, e;
        logic [DW-1:0] thr;
        logic md;
        for (int run = 0; run < 4; run++) begin
            for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 15));
            thr = DW'($urandom_range(6, 14));
            md  = run[0];
            launch(thr, md, model(thr, md));
            wait_done(cyc);
            checks++; if (cyc !== 39) begin errors++; $display("FAIL random%0d_done_cycle: got %0d expected 39", run, cyc); end
            r = dut_res(); e = exp_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL random%0d_results: got %h expected %h", run, r, e); end
        end
    endtask

    initial begin
        clear_image();
        @(negedge clk);
        test_reset();
        test_empty();
        test_two_pixels();
        test_mode();
        test_addr_seq();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
